// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared edit-mode encoding for the digital clock front end and
//                the hour/min/sec counter stage, plus button index constants.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_NORMAL = 2'd0;
    localparam logic [MODE_W-1:0] MODE_HOUR   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_MIN    = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SEC    = 2'd3;

    // Bit positions of the three buttons in the packed button vectors
    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DW   = 2;
    localparam int BTN_N    = 3;

    typedef enum logic [MODE_W-1:0] {
        ST_NORMAL = MODE_NORMAL,
        ST_HOUR   = MODE_HOUR,
        ST_MIN    = MODE_MIN,
        ST_SEC    = MODE_SEC
    } mode_e;

    // Edit-field rotation, wrapping from SET_SEC back to NORMAL
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            ST_NORMAL: nxt = ST_HOUR;
            ST_HOUR:   nxt = ST_MIN;
            ST_MIN:    nxt = ST_SEC;
            default:   nxt = ST_NORMAL;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser followed by a stability counter for one
//                asynchronous push-button. The accepted level only changes
//                after the synchronised input has differed from it for
//                DEB_CNT consecutive cycles. btn_rise pulses for one cycle,
//                aligned with the first cycle btn_deb is high.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEB_CNT = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_deb,
    output logic btn_rise
);

    localparam int             CNT_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             rise_q, rise_d;

    // Synchroniser shift, stability counter and accepted-level update
    always_comb begin
        sync_d = {sync_q[0], btn_raw};
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = deb_d & ~deb_q;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
        end
    end

    assign btn_deb  = deb_q;
    assign btn_rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_mode_ctrl
//  Description : Front-end controller of the digital clock. Debounces the
//                mode/up/down buttons, steps the edit field on each mode
//                press and qualifies up/down into ena_up/ena_dw for the
//                counter stage. Optional idle timeout back to NORMAL is
//                built when MODE_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CNT   = 500000,
    parameter int TIMEOUT_S = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_dw,
    output logic [MODE_W-1:0] select_mode,
    output logic              ena_up,
    output logic              ena_dw
);

    // ------------------------------------------------------------------
    // Reset conditioning: asserts immediately, releases on a clock edge
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    // Two-stage release synchroniser for the internal reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [BTN_N-1:0] btn_raw_w;
    logic [BTN_N-1:0] deb_w;
    logic [BTN_N-1:0] rise_w;

    assign btn_raw_w[BTN_MODE] = btn_mode;
    assign btn_raw_w[BTN_UP]   = btn_up;
    assign btn_raw_w[BTN_DW]   = btn_dw;

    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
        btn_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_int_n),
            .btn_raw  (btn_raw_w[i]),
            .btn_deb  (deb_w[i]),
            .btn_rise (rise_w[i])
        );
    end

    // Only the mode button uses its rising-edge pulse
    logic unused_rise_w;
    assign unused_rise_w = rise_w[BTN_UP] | rise_w[BTN_DW];

    // ------------------------------------------------------------------
    // Optional idle timeout
    // ------------------------------------------------------------------
    mode_e mode_q, mode_d;
    logic  timeout_w;

`ifdef MODE_TIMEOUT_EN
    localparam int               IDLE_W    = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Count idle 1 Hz ticks in edit modes; any held button restarts the count
    always_comb begin
        idle_d    = idle_q;
        timeout_w = 1'b0;
        if ((mode_q == ST_NORMAL) || (|deb_w)) begin
            idle_d = '0;
        end else if (ena) begin
            if (idle_q == IDLE_LAST) begin
                timeout_w = 1'b1;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // Without the timeout, edit modes persist and the 1 Hz tick is not needed
    logic unused_ena_w;
    assign unused_ena_w = ena;
    assign timeout_w    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------

    // Next edit field: a mode press always wins over a same-cycle timeout
    always_comb begin
        mode_d = mode_q;
        if (rise_w[BTN_MODE]) begin
            mode_d = next_mode(mode_q);
        end else if (timeout_w) begin
            mode_d = ST_NORMAL;
        end
    end

    // Mode state register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            mode_q <= ST_NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Up/down qualification with re-arm after a mode change
    // ------------------------------------------------------------------
    logic mode_chg_w;
    logic arm_up_q, arm_up_d;
    logic arm_dw_q, arm_dw_d;
    logic ena_up_q, ena_up_d;
    logic ena_dw_q, ena_dw_d;

    assign mode_chg_w = (mode_d != mode_q);

    // A mode change disarms both buttons until they have been seen released;
    // the enables drop in the same cycle the new mode is registered
    always_comb begin
        arm_up_d = arm_up_q;
        arm_dw_d = arm_dw_q;
        ena_up_d = 1'b0;
        ena_dw_d = 1'b0;
        if (mode_chg_w) begin
            arm_up_d = 1'b0;
            arm_dw_d = 1'b0;
        end else begin
            if (!deb_w[BTN_UP]) arm_up_d = 1'b1;
            if (!deb_w[BTN_DW]) arm_dw_d = 1'b1;
            if (mode_q != ST_NORMAL) begin
                ena_up_d = deb_w[BTN_UP] & ~deb_w[BTN_DW] & arm_up_q;
                ena_dw_d = deb_w[BTN_DW] & ~deb_w[BTN_UP] & arm_dw_q;
            end
        end
    end

    // Re-arm flags and registered enables
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            arm_up_q <= 1'b0;
            arm_dw_q <= 1'b0;
            ena_up_q <= 1'b0;
            ena_dw_q <= 1'b0;
        end else begin
            arm_up_q <= arm_up_d;
            arm_dw_q <= arm_dw_d;
            ena_up_q <= ena_up_d;
            ena_dw_q <= ena_dw_d;
        end
    end

    assign select_mode = mode_q;
    assign ena_up      = ena_up_q;
    assign ena_dw      = ena_dw_q;

endmodule
`default_nettype wire
